// File: rtl/gen_fifo_sync_ctl_pkg.sv
// Shared types and helpers for the synchronous FIFO controller family.
package gen_fifo_pkg;

  localparam int GEN_FIFO_PTR_WIDTH_DFLT = 4;
  // Pointers are PTR_WIDTH+1 bits; the extra MSB flips once per lap of the RAM.
  localparam int GEN_FIFO_PTR_WRAP_BIT   = GEN_FIFO_PTR_WIDTH_DFLT;

  typedef struct packed {
    logic full;
    logic empty;
    logic afull;
    logic aempty;
  } fifo_flags_t;

  localparam fifo_flags_t GEN_FIFO_FLAGS_RST = '{full: 1'b0, empty: 1'b1, afull: 1'b0, aempty: 1'b1};

  function automatic int fifo_depth(input int ptr_width);
    return 2 ** ptr_width;
  endfunction

  function automatic logic [31:0] ptr_inc(input logic [31:0] ptr);
    return ptr + 32'd1;
  endfunction

endpackage

// File: rtl/gen_fifo_sync_ctl_if.sv
// Handshake/status bundle between a FIFO user (master) and gen_fifo_sync_ctl (slave).
interface gen_fifo_sync_ctl_if #(
  parameter int PTR_WIDTH = 4
);
  logic                 clr;
  logic                 push;
  logic                 pop;
  logic [PTR_WIDTH:0]   af_level;
  logic [PTR_WIDTH:0]   ae_level;
  logic [PTR_WIDTH:0]   fifo_count;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_afull;
  logic                 fifo_aempty;
  logic                 ram_write_strobe;
  logic [PTR_WIDTH-1:0] ram_write_addr;
  logic                 ram_read_strobe;
  logic [PTR_WIDTH-1:0] ram_read_addr;
  logic                 fifo_ovf;
  logic                 fifo_udf;

  modport master (
    output clr, push, pop, af_level, ae_level,
    input  fifo_count, fifo_full, fifo_empty, fifo_afull, fifo_aempty,
           ram_write_strobe, ram_write_addr, ram_read_strobe, ram_read_addr,
           fifo_ovf, fifo_udf
  );

  modport slave (
    input  clr, push, pop, af_level, ae_level,
    output fifo_count, fifo_full, fifo_empty, fifo_afull, fifo_aempty,
           ram_write_strobe, ram_write_addr, ram_read_strobe, ram_read_addr,
           fifo_ovf, fifo_udf
  );
endinterface

// File: rtl/gen_fifo_ptr.sv
// PTR_WIDTH+1 bit FIFO pointer with wrap bit: increments on en_i, zeroes on clr_i.
module gen_fifo_ptr
  import gen_fifo_pkg::*;
#(
  parameter int PTR_WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en_i,
  input  logic               clr_i,
  output logic [PTR_WIDTH:0] ptr_o,
  output logic [PTR_WIDTH:0] ptr_next_o
);

  logic [PTR_WIDTH:0] ptr_q;
  logic [PTR_WIDTH:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (clr_i) begin
      ptr_d = '0;
    end else if (en_i) begin
      ptr_d = (PTR_WIDTH + 1)'(ptr_inc(32'(ptr_q)));
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o      = ptr_q;
  assign ptr_next_o = ptr_d;

endmodule

// File: rtl/gen_fifo_sync_ctl.sv
// Single-clock FIFO controller for an external dual-port RAM with exact count and
// registered flags. Define GEN_FIFO_SYNC_ERR_EN to build sticky overflow/underflow flags.
module gen_fifo_sync_ctl
  import gen_fifo_pkg::*;
#(
  parameter int PTR_WIDTH      = 4,
  parameter int RESET_AF_LEVEL = 2 ** PTR_WIDTH - 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gen_fifo_sync_ctl_if.slave    bus
);

  localparam logic [PTR_WIDTH:0] DEPTH = (PTR_WIDTH + 1)'(fifo_depth(PTR_WIDTH));

  if (PTR_WIDTH < 1 || RESET_AF_LEVEL < 0 || RESET_AF_LEVEL > 2 ** PTR_WIDTH) begin : g_bad_cfg
    $error("gen_fifo_sync_ctl: illegal PTR_WIDTH/RESET_AF_LEVEL");
  end

  logic                 push_ok;
  logic                 pop_ok;
  logic [PTR_WIDTH:0]   wr_ptr, wr_ptr_next;
  logic [PTR_WIDTH:0]   rd_ptr, rd_ptr_next;
  logic [PTR_WIDTH+1:0] count_sum;
  logic [PTR_WIDTH:0]   count_q, count_d;
  fifo_flags_t          flags_q, flags_d;

  // A push into a full FIFO is safe when a pop frees a slot in the same cycle.
  assign push_ok = bus.push & (~flags_q.full | bus.pop);
  assign pop_ok  = bus.pop & ~flags_q.empty;

  gen_fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_wr_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (push_ok),
    .clr_i      (bus.clr),
    .ptr_o      (wr_ptr),
    .ptr_next_o (wr_ptr_next)
  );

  gen_fifo_ptr #(.PTR_WIDTH(PTR_WIDTH)) u_rd_ptr (
    .clk        (clk),
    .rst_n      (rst_n),
    .en_i       (pop_ok),
    .clr_i      (bus.clr),
    .ptr_o      (rd_ptr),
    .ptr_next_o (rd_ptr_next)
  );

  assign count_sum = {1'b0, count_q} + (PTR_WIDTH + 2)'(push_ok) - (PTR_WIDTH + 2)'(pop_ok);

  // NOTE: every output of this block gets a value on every path, so no latch is inferred.
  always_comb begin
    count_d        = count_sum[PTR_WIDTH:0];
    flags_d.full   = (count_d == DEPTH);
    flags_d.empty  = (count_d == '0);
    flags_d.afull  = (count_d >= bus.af_level);
    flags_d.aempty = (count_d <= bus.ae_level);
    if (bus.clr) begin
      count_d = '0;
      flags_d = GEN_FIFO_FLAGS_RST;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      flags_q <= GEN_FIFO_FLAGS_RST;
    end else begin
      count_q <= count_d;
      flags_q <= flags_d;
    end
  end

  // Occupancy must always equal the pointer distance, including across flushes.
  assert property (@(posedge clk) disable iff (!rst_n) count_d == (wr_ptr_next - rd_ptr_next));

`ifdef GEN_FIFO_SYNC_ERR_EN
  logic ovf_q, udf_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else if (bus.clr) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (bus.push & ~push_ok) ovf_q <= 1'b1;
      if (bus.pop & ~pop_ok)   udf_q <= 1'b1;
    end
  end

  assign bus.fifo_ovf = ovf_q;
  assign bus.fifo_udf = udf_q;
`else
  assign bus.fifo_ovf = 1'b0;
  assign bus.fifo_udf = 1'b0;
`endif

  assign bus.fifo_count       = count_q;
  assign bus.fifo_full        = flags_q.full;
  assign bus.fifo_empty       = flags_q.empty;
  assign bus.fifo_afull       = flags_q.afull;
  assign bus.fifo_aempty      = flags_q.aempty;
  assign bus.ram_write_strobe = push_ok;
  assign bus.ram_write_addr   = wr_ptr[PTR_WIDTH-1:0];
  assign bus.ram_read_strobe  = pop_ok;
  assign bus.ram_read_addr    = rd_ptr[PTR_WIDTH-1:0];

endmodule

// File: tb/tb_gen_fifo_sync_ctl.sv
// Directed-vector bench for gen_fifo_sync_ctl at PTR_WIDTH=2 (depth 4).
module tb_gen_fifo_sync_ctl;

`ifdef GEN_FIFO_SYNC_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  gen_fifo_sync_ctl_if #(.PTR_WIDTH(2)) bus ();

  gen_fifo_sync_ctl #(.PTR_WIDTH(2), .RESET_AF_LEVEL(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // status = {count[2:0], full, empty, afull, aempty, ovf, udf}
  function automatic logic [8:0] st_now();
    return {bus.fifo_count, bus.fifo_full, bus.fifo_empty, bus.fifo_afull,
            bus.fifo_aempty, bus.fifo_ovf, bus.fifo_udf};
  endfunction

  function automatic logic [8:0] st_exp(int c, bit af, bit ae, bit o, bit u);
    logic [2:0] cc;
    cc = 3'(c);
    return {cc, (c == 4), (c == 0), af, ae, o, u};
  endfunction

  // strobes = {wr_strobe, wr_addr[1:0], rd_strobe, rd_addr[1:0]}
  function automatic logic [5:0] sb_now();
    return {bus.ram_write_strobe, bus.ram_write_addr, bus.ram_read_strobe, bus.ram_read_addr};
  endfunction

  function automatic logic [5:0] sb_exp(bit ws, int wa, bit rs, int ra);
    logic [1:0] a, b;
    a = 2'(wa);
    b = 2'(ra);
    return {ws, a, rs, b};
  endfunction

  task automatic drive(input bit psh, input bit pp, input bit cl);
    bus.push = psh;
    bus.pop  = pp;
    bus.clr  = cl;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(0, 0, 0);
    bus.af_level = 3'd4;
    bus.ae_level = 3'd0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (st_now() !== st_exp(0, 0, 1, 0, 0)) begin
      miscompares++;
      $display("FAIL reset status: got %b want %b", st_now(), st_exp(0, 0, 1, 0, 0));
    end
    vectors++;
    if (sb_now() !== sb_exp(0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL reset strobes: got %b want %b", sb_now(), sb_exp(0, 0, 0, 0));
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_fill_overflow();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1, 0, 0); #1;
      vectors++;
      if (sb_now() !== sb_exp(1, i, 0, 0)) begin
        miscompares++;
        $display("FAIL fill%0d strobes: got %b want %b", i, sb_now(), sb_exp(1, i, 0, 0));
      end
      @(posedge clk); #1;
      vectors++;
      if (st_now() !== st_exp(i + 1, i == 3, 0, 0, 0)) begin
        miscompares++;
        $display("FAIL fill%0d status: got %b want %b", i, st_now(), st_exp(i + 1, i == 3, 0, 0, 0));
      end
    end
    @(negedge clk); drive(1, 0, 0); #1;
    vectors++;
    if (sb_now() !== sb_exp(0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL overflow strobes: got %b want %b", sb_now(), sb_exp(0, 0, 0, 0));
    end
    @(posedge clk); #1;
    vectors++;
    if (st_now() !== st_exp(4, 1, 0, ERR, 0)) begin
      miscompares++;
      $display("FAIL overflow status: got %b want %b", st_now(), st_exp(4, 1, 0, ERR, 0));
    end
  endtask

  task automatic test_full_push_pop();
    @(negedge clk); drive(1, 1, 0); #1;
    vectors++;
    if (sb_now() !== sb_exp(1, 0, 1, 0)) begin
      miscompares++;
      $display("FAIL full_pp strobes: got %b want %b", sb_now(), sb_exp(1, 0, 1, 0));
    end
    @(posedge clk); #1;
    vectors++;
    if (st_now() !== st_exp(4, 1, 0, ERR, 0)) begin
      miscompares++;
      $display("FAIL full_pp status: got %b want %b", st_now(), st_exp(4, 1, 0, ERR, 0));
    end
    // Drain: write pointer sits at 5 (addr 1), read pointer runs 1,2,3,0.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(0, 1, 0); #1;
      vectors++;
      if (sb_now() !== sb_exp(0, 1, 1, (1 + i) % 4)) begin
        miscompares++;
        $display("FAIL drain%0d strobes: got %b want %b", i, sb_now(), sb_exp(0, 1, 1, (1 + i) % 4));
      end
      @(posedge clk); #1;
      vectors++;
      if (st_now() !== st_exp(3 - i, 0, i == 3, ERR, 0)) begin
        miscompares++;
        $display("FAIL drain%0d status: got %b want %b", i, st_now(), st_exp(3 - i, 0, i == 3, ERR, 0));
      end
    end
  endtask

  task automatic test_empty_push_pop();
    @(negedge clk); drive(1, 1, 0); #1;
    vectors++;
    if (sb_now() !== sb_exp(1, 1, 0, 1)) begin
      miscompares++;
      $display("FAIL empty_pp strobes: got %b want %b", sb_now(), sb_exp(1, 1, 0, 1));
    end
    @(posedge clk); #1;
    vectors++;
    if (st_now() !== st_exp(1, 0, 0, ERR, ERR)) begin
      miscompares++;
      $display("FAIL empty_pp status: got %b want %b", st_now(), st_exp(1, 0, 0, ERR, ERR));
    end
    @(negedge clk); drive(0, 0, 0);
  endtask

  task automatic test_thresholds();
    bit exp_af [4] = '{0, 0, 1, 1};
    bit exp_ae [4] = '{1, 0, 0, 0};
    bus.af_level = 3'd3;
    bus.ae_level = 3'd1;
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); drive(1, 0, 0);
      @(posedge clk); #1;
      vectors++;
      if (st_now() !== st_exp(i + 1, exp_af[i], exp_ae[i], 0, 0)) begin
        miscompares++;
        $display("FAIL thresh%0d status: got %b want %b", i, st_now(), st_exp(i + 1, exp_af[i], exp_ae[i], 0, 0));
      end
    end
    // af_level 0 forces afull, ae_level >= depth forces aempty.
    @(negedge clk); drive(0, 0, 0); bus.af_level = 3'd0; bus.ae_level = 3'd4;
    @(posedge clk); #1;
    vectors++;
    if (st_now() !== st_exp(4, 1, 1, 0, 0)) begin
      miscompares++;
      $display("FAIL thresh_force status: got %b want %b", st_now(), st_exp(4, 1, 1, 0, 0));
    end
    @(negedge clk); bus.af_level = 3'd5; bus.ae_level = 3'd3;
    @(posedge clk); #1;
    vectors++;
    if (st_now() !== st_exp(4, 0, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL thresh_out status: got %b want %b", st_now(), st_exp(4, 0, 0, 0, 0));
    end
    bus.af_level = 3'd4;
    bus.ae_level = 3'd0;
  endtask

  task automatic test_wrap();
    apply_reset();
    @(negedge clk); drive(1, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); drive(1, 1, 0); #1;
      vectors++;
      if (sb_now() !== sb_exp(1, (1 + i) % 4, 1, i % 4)) begin
        miscompares++;
        $display("FAIL wrap%0d strobes: got %b want %b", i, sb_now(), sb_exp(1, (1 + i) % 4, 1, i % 4));
      end
      @(posedge clk); #1;
      vectors++;
      if (st_now() !== st_exp(1, 0, 0, 0, 0)) begin
        miscompares++;
        $display("FAIL wrap%0d status: got %b want %b", i, st_now(), st_exp(1, 0, 0, 0, 0));
      end
    end
    // Pointers are now wr=11, rd=10; fill until the low bits meet with opposite wrap bits.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1, 0, 0); #1;
      vectors++;
      if (sb_now() !== sb_exp(1, (3 + i) % 4, 0, 2)) begin
        miscompares++;
        $display("FAIL wrapfill%0d strobes: got %b want %b", i, sb_now(), sb_exp(1, (3 + i) % 4, 0, 2));
      end
      @(posedge clk); #1;
      vectors++;
      if (st_now() !== st_exp(2 + i, i == 2, 0, 0, 0)) begin
        miscompares++;
        $display("FAIL wrapfill%0d status: got %b want %b", i, st_now(), st_exp(2 + i, i == 2, 0, 0, 0));
      end
    end
  endtask

  task automatic test_clr_and_async_reset();
    apply_reset();
    @(negedge clk); drive(0, 1, 0);
    @(posedge clk); #1;
    vectors++;
    if (st_now() !== st_exp(0, 0, 1, 0, ERR)) begin
      miscompares++;
      $display("FAIL underflow status: got %b want %b", st_now(), st_exp(0, 0, 1, 0, ERR));
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(1, 0, 0);
      @(posedge clk); #1;
    end
    @(negedge clk); drive(1, 0, 1); #1;
    vectors++;
    if (sb_now() !== sb_exp(1, 3, 0, 0)) begin
      miscompares++;
      $display("FAIL clr strobes: got %b want %b", sb_now(), sb_exp(1, 3, 0, 0));
    end
    @(posedge clk); #1;
    vectors++;
    if (st_now() !== st_exp(0, 0, 1, 0, 0)) begin
      miscompares++;
      $display("FAIL clr status: got %b want %b", st_now(), st_exp(0, 0, 1, 0, 0));
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(1, 0, 0); #1;
      vectors++;
      if (sb_now() !== sb_exp(1, i, 0, 0)) begin
        miscompares++;
        $display("FAIL postclr%0d strobes: got %b want %b", i, sb_now(), sb_exp(1, i, 0, 0));
      end
      @(posedge clk); #1;
      vectors++;
      if (st_now() !== st_exp(i + 1, 0, 0, 0, 0)) begin
        miscompares++;
        $display("FAIL postclr%0d status: got %b want %b", i, st_now(), st_exp(i + 1, 0, 0, 0, 0));
      end
    end
    // Async reset pulsed between edges with a push still requested.
    @(negedge clk); drive(1, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (st_now() !== st_exp(0, 0, 1, 0, 0)) begin
      miscompares++;
      $display("FAIL async_rst status: got %b want %b", st_now(), st_exp(0, 0, 1, 0, 0));
    end
    vectors++;
    if (sb_now() !== sb_exp(1, 0, 0, 0)) begin
      miscompares++;
      $display("FAIL async_rst strobes: got %b want %b", sb_now(), sb_exp(1, 0, 0, 0));
    end
    @(posedge clk); #1;
    vectors++;
    if (st_now() !== st_exp(0, 0, 1, 0, 0)) begin
      miscompares++;
      $display("FAIL async_rst_hold status: got %b want %b", st_now(), st_exp(0, 0, 1, 0, 0));
    end
    @(negedge clk); rst_n = 1'b1; drive(0, 0, 0);
  endtask

  initial begin
    test_reset();
    test_fill_overflow();
    test_full_push_pop();
    test_empty_push_pop();
    test_thresholds();
    test_wrap();
    test_clr_and_async_reset();
    repeat (2) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/gen_fifo_sync_ctl.md
Name: gen_fifo_sync_ctl

Overview:
Single-clock FIFO controller. It is the synchronous, fully-guarded successor to the async write controller, and it owns both the write and read pointers for one external dual-port RAM. It adds programmable almost-full/almost-empty thresholds, overflow/underflow protection, a synchronous flush, and an occupancy count exact in the same cycle. It is used wherever producer and consumer share a clock, for example AXI-slave command and data queues.

Parameters:
PTR_WIDTH, 4, RAM address width; FIFO depth = 2**PTR_WIDTH (PTR_WIDTH >= 1).
RESET_AF_LEVEL, 2**PTR_WIDTH-1, value af_level is assumed to hold for the first cycle after reset (documentation only; af_level is sampled every cycle).

Ports:
clk  input  1  clock, all logic rising-edge.
rst_n  input  1  asynchronous active-low reset.
clr  input  1  synchronous flush: pointers/count to 0, same timing as reset.
push  input  1  write request.
pop  input  1  read request.
af_level  input  PTR_WIDTH+1  almost-full threshold (count >= af_level).
ae_level  input  PTR_WIDTH+1  almost-empty threshold (count <= ae_level).
fifo_count  output  PTR_WIDTH+1  current occupancy 0..2**PTR_WIDTH.
fifo_full  output  1  count == 2**PTR_WIDTH.
fifo_empty  output  1  count == 0.
fifo_afull  output  1  almost full.
fifo_aempty  output  1  almost empty.
ram_write_strobe  output  1  accepted push, write RAM this cycle.
ram_write_addr  output  PTR_WIDTH  RAM write address.
ram_read_strobe  output  1  accepted pop, read RAM this cycle.
ram_read_addr  output  PTR_WIDTH  RAM read address.
fifo_ovf  output  1  sticky: push rejected because full (only with GEN_FIFO_SYNC_ERR_EN).
fifo_udf  output  1  sticky: pop rejected because empty (only with GEN_FIFO_SYNC_ERR_EN).

Behaviour:
- Reset (rst_n low, async): wr_ptr = rd_ptr = 0 (PTR_WIDTH+1 bits, MSB is the wrap bit). Outputs: count 0, empty 1, full 0, afull 0, aempty 1, ovf/udf 0.
- Acceptance, combinational from current registered state:
  - push_ok = push & (~full | pop).
  - pop_ok = pop & ~empty.
- Full plus push plus pop: both are accepted and the count is unchanged.
- Empty plus push plus pop: push is accepted, pop is rejected, and the count goes to 1.
- ram_write_strobe = push_ok; ram_read_strobe = pop_ok. Both are combinational.
- Addresses are the low PTR_WIDTH bits of the registered pointers.
- RAM read data is valid one cycle after ram_read_strobe; the external RAM owns it and this block has no FWFT.
- Pointers increment by 1 modulo 2**(PTR_WIDTH+1) on push_ok/pop_ok. The wrap bit distinguishes full from empty when the low bits are equal.
- fifo_count is registered and updated from count_next:
  - count_next = count + push_ok - pop_ok, computed PTR_WIDTH+2 wide then truncated.
  - It never exceeds 2**PTR_WIDTH.
- full, empty, afull and aempty are registered, derived from count_next. They are therefore consistent with fifo_count in the same cycle, with no extra lag.
- Threshold compares are unsigned, PTR_WIDTH+1 wide:
  - af_level = 0 forces afull = 1.
  - ae_level >= 2**PTR_WIDTH forces aempty = 1.
  - Thresholds may change at any time; the new value takes effect on the next registered update.
- clr has priority over push/pop in the same cycle:
  - State goes to the reset values at the next edge; the sticky flags are also cleared.
  - Strobes are still driven combinationally from the pre-clear state. Accepted accesses that cycle are discarded.
- Reset mid-operation: asynchronous return to reset values. There is no partial pointer state.

Optional Feature:
- Macro: GEN_FIFO_SYNC_ERR_EN.
- Defined:
  - fifo_ovf is set at the edge after push & ~push_ok.
  - fifo_udf is set at the edge after pop & ~pop_ok.
  - Both are sticky until rst_n or clr.
- Undefined: the error registers are not built, both ports are tied 0, and there is no other behaviour change.

Decomposition:
- Shared package gen_fifo_pkg holds:
  - function fifo_depth(PTR_WIDTH) = 2**PTR_WIDTH;
  - a pointer-increment helper;
  - constant GEN_FIFO_PTR_WRAP_BIT = PTR_WIDTH.
- Natural sub-module: gen_fifo_ptr. One instance each for write and read. It holds the PTR_WIDTH+1 register with async reset, enable, sync clear, and outputs ptr and ptr_next.
- Count, flag and error logic stay in the top module.

Test Plan:
1. PTR_WIDTH=2: 4 pushes after reset → write addrs 0,1,2,3; count 1,2,3,4; full=1 after the 4th edge. A 5th push → no strobe, count stays 4, ovf=1 (with ERR_EN).
2. From full: push+pop in one cycle → both strobes, write addr 0, read addr 0, count stays 4, full stays 1.
3. From empty: push+pop → write strobe only, no read strobe, count=1, udf=1 (with ERR_EN).
4. af_level=3, ae_level=1: fill 0→4 → afull rises with count=3, aempty falls with count=2.
5. Wrap: 10 push/pop pairs interleaved → addresses wrap 3→0, wrap bit toggles, empty/full never falsely asserted.
6. At count=3, assert clr with push → next cycle count=0, empty=1, pointers 0, ovf/udf cleared; separately, rst_n pulsed mid-burst → immediate reset values.
